// File: rtl/cache_tag_ctrl_pkg.sv
// rtl/cache_tag_ctrl_pkg.sv - shared state codes and geometry for the cache tag controller
package cache_tag_ctrl_pkg;

    localparam int DEF_INDEX_BITS = 3;
    localparam int DEF_ADDR_BITS  = 5;
    localparam int DEF_TAG_BITS   = DEF_ADDR_BITS - DEF_INDEX_BITS;

    // Sequencer state codes; these values are visible on the state port.
    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_COMPARE    = 4'd1,
        ST_READ_HIT   = 4'd2,
        ST_MEM_READ   = 4'd3,
        ST_FILL       = 4'd4,
        ST_CACHE_READ = 4'd5,
        ST_WRITE      = 4'd6,
        ST_DONE       = 4'd7
    } state_t;

endpackage

// File: rtl/cache_tag_valid_array.sv
// rtl/cache_tag_valid_array.sv - tag and valid storage for a direct-mapped cache
//
// Ports:
//   clk, rst   : clock and asynchronous active-high reset (clears all tags and valids)
//   i_we       : write enable; stores i_tag and sets valid at i_index
//   i_index    : line index for both read and write
//   i_tag      : tag to store
//   o_tag      : stored tag at i_index (combinational)
//   o_valid    : valid bit at i_index (combinational)
module cache_tag_valid_array #(
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [INDEX_BITS-1:0] i_index,
    input  logic [TAG_BITS-1:0]   i_tag,
    output logic [TAG_BITS-1:0]   o_tag,
    output logic                  o_valid
);

    localparam int LINES = 2 ** INDEX_BITS;

    logic [TAG_BITS-1:0] r_tag [LINES];
    logic [LINES-1:0]    r_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LINES; i++) begin
                r_tag[i] <= '0;
            end
            r_valid <= '0;
        end else if (i_we) begin
            r_tag[i_index]   <= i_tag;
            r_valid[i_index] <= 1'b1;
        end
    end

    assign o_tag   = r_tag[i_index];
    assign o_valid = r_valid[i_index];

endmodule

// File: rtl/cache_tag_ctrl.sv
// rtl/cache_tag_ctrl.sv - hit detection and strobe sequencer for a write-through, write-allocate cache
//
// Ports:
//   clk, reset              : clock and asynchronous active-high reset
//   fulladdress             : CPU address; low INDEX_BITS are the index, the rest the tag
//   read_signal             : CPU read request (sampled in IDLE)
//   write_signal            : CPU write request (sampled in IDLE, wins over read)
//   state                   : current sequencer state code
//   hit                     : combinational tag match with a valid line
//   read_signal_cache       : read data RAM
//   write_signal_cache_out  : write CPU data into data RAM
//   write_signal_cache_mem  : write memory data into data RAM (line fill)
//   read_signal_memory      : read main memory
//   write_signal_memory     : write CPU data to main memory
module cache_tag_ctrl
    import cache_tag_ctrl_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int ADDR_BITS  = DEF_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] fulladdress,
    input  logic                 read_signal,
    input  logic                 write_signal,
    output logic [3:0]           state,
    output logic                 hit,
    output logic                 read_signal_cache,
    output logic                 write_signal_cache_out,
    output logic                 write_signal_cache_mem,
    output logic                 read_signal_memory,
    output logic                 write_signal_memory
);

    localparam int TAG_BITS = ADDR_BITS - INDEX_BITS;

    state_t                r_state;
    logic [INDEX_BITS-1:0] w_index;
    logic [TAG_BITS-1:0]   w_addr_tag;
    logic [TAG_BITS-1:0]   w_stored_tag;
    logic                  w_stored_valid;
    logic                  w_array_we;

    assign w_index    = fulladdress[INDEX_BITS-1:0];
    assign w_addr_tag = fulladdress[ADDR_BITS-1:INDEX_BITS];

    // Both fill and CPU write allocate the line, so either data-RAM write updates the tag.
    assign w_array_we = write_signal_cache_out | write_signal_cache_mem;

    cache_tag_valid_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clk     (clk),
        .rst     (reset),
        .i_we    (w_array_we),
        .i_index (w_index),
        .i_tag   (w_addr_tag),
        .o_tag   (w_stored_tag),
        .o_valid (w_stored_valid)
    );

    assign hit = w_stored_valid && (w_stored_tag == w_addr_tag);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (write_signal) begin
                        r_state <= ST_WRITE;
                    end else if (read_signal) begin
                        r_state <= ST_COMPARE;
                    end
                end
                ST_COMPARE:    r_state <= hit ? ST_READ_HIT : ST_MEM_READ;
                ST_READ_HIT:   r_state <= ST_DONE;
                ST_MEM_READ:   r_state <= ST_FILL;
                ST_FILL:       r_state <= ST_CACHE_READ;
                ST_CACHE_READ: r_state <= ST_DONE;
                ST_WRITE:      r_state <= ST_DONE;
                ST_DONE:       r_state <= ST_IDLE;
                default:       r_state <= ST_IDLE;
            endcase
        end
    end

    assign state = r_state;

    // Moore decode straight from the state register so reset kills every strobe at once.
    assign read_signal_cache      = (r_state == ST_READ_HIT) || (r_state == ST_CACHE_READ);
    assign write_signal_cache_out = (r_state == ST_WRITE);
    assign write_signal_cache_mem = (r_state == ST_FILL);
    assign read_signal_memory     = (r_state == ST_MEM_READ);
    assign write_signal_memory    = (r_state == ST_WRITE);

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// tb/tb_cache_tag_ctrl.sv - self-checking bench for cache_tag_ctrl
module tb_cache_tag_ctrl;

    localparam int IB = 3;
    localparam int AB = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [AB-1:0] fulladdress;
    logic          read_signal;
    logic          write_signal;
    logic [3:0]    state;
    logic          hit;
    logic          read_signal_cache;
    logic          write_signal_cache_out;
    logic          write_signal_cache_mem;
    logic          read_signal_memory;
    logic          write_signal_memory;

    int tests = 0;
    int fails = 0;

    // Reference cache contents
    logic [1:0] m_tag [8];
    logic       m_valid [8];

    cache_tag_ctrl #(.INDEX_BITS(IB), .ADDR_BITS(AB)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .fulladdress            (fulladdress),
        .read_signal            (read_signal),
        .write_signal           (write_signal),
        .state                  (state),
        .hit                    (hit),
        .read_signal_cache      (read_signal_cache),
        .write_signal_cache_out (write_signal_cache_out),
        .write_signal_cache_mem (write_signal_cache_mem),
        .read_signal_memory     (read_signal_memory),
        .write_signal_memory    (write_signal_memory)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] strobes_now();
        return {read_signal_cache, write_signal_cache_out, write_signal_cache_mem,
                read_signal_memory, write_signal_memory};
    endfunction

    // Strobe table: {rd_cache, wr_cache_out, wr_cache_mem, rd_mem, wr_mem}
    function automatic logic [4:0] strobe_table(input int s);
        case (s)
            2:       return 5'b10000;
            3:       return 5'b00010;
            4:       return 5'b00100;
            5:       return 5'b10000;
            6:       return 5'b01001;
            default: return 5'b00000;
        endcase
    endfunction

    function automatic logic model_hit(input logic [AB-1:0] a);
        return m_valid[a[2:0]] && (m_tag[a[2:0]] == a[4:3]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_tag[i]   = 2'b00;
            m_valid[i] = 1'b0;
        end
    endtask

    // Issue one request from IDLE and follow it cycle by cycle back to IDLE.
    task automatic run_op(input logic [AB-1:0] a, input logic rd, input logic wr, input string nm);
        int  seq[$];
        logic exp_hit;
        @(negedge clk);
        fulladdress  = a;
        read_signal  = rd;
        write_signal = wr;
        #1;
        exp_hit = model_hit(a);
        check({nm, " idle_state"}, 32'(state), 32'd0);
        check({nm, " idle_hit"}, 32'(hit), 32'(exp_hit));
        if (wr)           seq = '{6, 7, 0};
        else if (rd)      seq = exp_hit ? '{1, 2, 7, 0} : '{1, 3, 4, 5, 7, 0};
        else              seq = '{0};
        @(negedge clk);
        read_signal  = 1'b0;
        write_signal = 1'b0;
        foreach (seq[k]) begin
            if (k > 0) @(negedge clk);
            check($sformatf("%s step%0d state", nm, k), 32'(state), 32'(seq[k]));
            check($sformatf("%s step%0d strobes", nm, k), 32'(strobes_now()), 32'(strobe_table(seq[k])));
            if (seq[k] == 1) check({nm, " compare_hit"}, 32'(hit), 32'(exp_hit));
        end
        if (wr || (rd && !exp_hit)) begin
            m_tag[a[2:0]]   = a[4:3];
            m_valid[a[2:0]] = 1'b1;
        end
        #1;
        check({nm, " after_hit"}, 32'(hit), 32'(model_hit(a)));
    endtask

    initial begin
        reset        = 1'b1;
        fulladdress  = '0;
        read_signal  = 1'b0;
        write_signal = 1'b0;
        model_reset();
        #12;
        check("reset state", 32'(state), 32'd0);
        check("reset strobes", 32'(strobes_now()), 32'd0);
        check("reset hit", 32'(hit), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op(5'b10_011, 1'b1, 1'b0, "rd_miss_10011");
        run_op(5'b10_011, 1'b1, 1'b0, "rd_hit_10011");
        run_op(5'b01_011, 1'b1, 1'b0, "rd_conflict_01011");
        run_op(5'b10_011, 1'b1, 1'b0, "rd_remiss_10011");
        run_op(5'b11_101, 1'b0, 1'b1, "wr_11101");
        run_op(5'b11_101, 1'b1, 1'b0, "rd_after_wr_11101");
        run_op(5'b00_001, 1'b1, 1'b1, "both_00001");
        run_op(5'b00_001, 1'b1, 1'b0, "rd_after_both");
        run_op(5'b00_010, 1'b0, 1'b0, "no_req");

        // Abort a line fill with an async reset between clock edges.
        @(negedge clk);
        fulladdress = 5'b01_110;
        read_signal = 1'b1;
        @(negedge clk);
        read_signal = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_abort state", 32'(state), 32'd4);
        #2;
        reset = 1'b1;
        #1;
        check("abort state", 32'(state), 32'd0);
        check("abort strobes", 32'(strobes_now()), 32'd0);
        model_reset();
        for (int i = 0; i < 32; i++) begin
            fulladdress = 5'(i);
            #0.1;
            check($sformatf("abort hit a%0d", i), 32'(hit), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        run_op(5'b11_101, 1'b1, 1'b0, "rd_after_abort_11101");

        for (int n = 0; n < 60; n++) begin
            logic [AB-1:0] ra;
            logic [1:0]    op;
            ra = 5'($urandom_range(0, 31));
            op = 2'($urandom_range(0, 3));
            run_op(ra, op[0] | (op == 2'd0), op[1], $sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
